// File: rtl/dm_ctrl.sv
// Data-memory access controller: serialises one core load/store at a time onto
// the data-memory port and returns a registered response with per-type counters.
module dm_ctrl #(
  parameter int unsigned RD_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [15:0] dm_read_addr,
  output logic [15:0] dm_write_addr,
  output logic [31:0] dm_write_data,
  output logic        dm_we,
  input  logic [31:0] dm_read_data,
  output logic [15:0] n_loads,
  output logic [15:0] n_stores
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_WAIT = 3'd1;
  localparam logic [2:0] ST_WR_HI   = 3'd2;
  localparam logic [2:0] ST_WR_LO   = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  logic [2:0]  state;
  logic [3:0]  wait_cnt;
  logic        resp_is_load;
  logic [15:0] load_cnt;
  logic [15:0] store_cnt;

  // Gated by rst_f so the core sees "not ready" for the whole reset window.
  assign req_ready = (state == ST_IDLE) && rst_f;
  assign n_loads   = load_cnt;
  assign n_stores  = store_cnt;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      resp_is_load  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      dm_read_addr  <= '0;
      dm_write_addr <= '0;
      dm_write_data <= '0;
      dm_we         <= 1'b0;
      load_cnt      <= '0;
      store_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            resp_is_load <= !req_we;
            if (req_we) begin
              dm_write_addr <= req_addr;
              dm_write_data <= req_wdata;
              state         <= ST_WR_HI;
            end else begin
              dm_read_addr <= req_addr;
              wait_cnt     <= 4'(RD_WAIT);
              state        <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (wait_cnt == 4'd1) begin
            rsp_rdata <= dm_read_data;
            rsp_valid <= 1'b1;
            wait_cnt  <= '0;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_WR_HI: begin
          dm_we <= 1'b1;
          state <= ST_WR_LO;
        end
        ST_WR_LO: begin
          // Falling dm_we here is the memory's write-commit strobe.
          dm_we     <= 1'b0;
          rsp_rdata <= '0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
            if (resp_is_load) load_cnt  <= load_cnt + 16'd1;
            else              store_cnt <= store_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: a behavioural memory/counter model predicts
// load data, latencies, write strobes and counters for directed and random traffic.
module tb_dm_ctrl;
  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, dm_we;
  logic [15:0] req_addr, dm_read_addr, dm_write_addr, n_loads, n_stores;
  logic [31:0] req_wdata, rsp_rdata, dm_write_data, dm_read_data;
  logic        req_valid4, req_ready4, req_we4, rsp_valid4, rsp_ready4, dm_we4;
  logic [15:0] req_addr4, dm_read_addr4, dm_write_addr4, n_loads4, n_stores4;
  logic [31:0] req_wdata4, rsp_rdata4, dm_write_data4, dm_read_data4;

  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_nl, exp_ns, exp_raddr, exp_waddr;
  logic [31:0] exp_wdata;

  dm_ctrl dut (
    .clk(clk), .rst_f(rst_f), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .dm_read_addr(dm_read_addr), .dm_write_addr(dm_write_addr),
    .dm_write_data(dm_write_data), .dm_we(dm_we), .dm_read_data(dm_read_data),
    .n_loads(n_loads), .n_stores(n_stores)
  );

  dm_ctrl #(.RD_WAIT(4)) dut4 (
    .clk(clk), .rst_f(rst_f), .req_valid(req_valid4), .req_ready(req_ready4), .req_we(req_we4),
    .req_addr(req_addr4), .req_wdata(req_wdata4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_rdata(rsp_rdata4), .dm_read_addr(dm_read_addr4), .dm_write_addr(dm_write_addr4),
    .dm_write_data(dm_write_data4), .dm_we(dm_we4), .dm_read_data(dm_read_data4),
    .n_loads(n_loads4), .n_stores(n_stores4)
  );

  always #5 clk = ~clk;

  assign dm_read_data  = mem[dm_read_addr];
  assign dm_read_data4 = mem[dm_read_addr4];
  always @(negedge dm_we) if (rst_f === 1'b1) mem[dm_write_addr] = dm_write_data;

  function automatic logic [31:0] init_val(input int unsigned a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Drives one transaction and reports what was observed; no judgement here.
  task automatic run_op(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                        input int unsigned hold, output logic [31:0] rd, output int lat,
                        output int we_cyc, output int we_at, output logic tmo);
    tmo = 1'b0; lat = 0; we_cyc = 0; we_at = -1; rd = '0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) begin @(posedge clk); #1; end
    if (req_ready !== 1'b1) tmo = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = $urandom;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      if (dm_we === 1'b1) begin we_cyc++; if (we_at < 0) we_at = lat; end
      @(posedge clk); #1; lat++;
    end
    if (rsp_valid !== 1'b1) tmo = 1'b1;
    rd = rsp_rdata;
    for (int unsigned i = 0; i < hold; i++) begin
      if (dm_we === 1'b1) we_cyc++;
      @(posedge clk); #1;
    end
    if (dm_we === 1'b1) we_cyc++;
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    if (dm_we === 1'b1) we_cyc++;
  endtask

  task automatic test_reset();
    rst_f = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rsp_rdata got %h exp 0", rsp_rdata); end
    n_vec++; if ({dm_read_addr, dm_write_addr, dm_write_data} !== 64'h0) begin n_err++; $display("FAIL rst_dm_bus got %h/%h/%h exp 0", dm_read_addr, dm_write_addr, dm_write_data); end
    n_vec++; if (dm_we !== 1'b0) begin n_err++; $display("FAIL rst_dm_we got %b exp 0", dm_we); end
    n_vec++; if ({n_loads, n_stores} !== 32'h0) begin n_err++; $display("FAIL rst_counters got %h/%h exp 0", n_loads, n_stores); end
    @(negedge clk); rst_f = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rel_req_ready got %b exp 1", req_ready); end
    n_vec++; if (req_ready4 !== 1'b1) begin n_err++; $display("FAIL rel_req_ready4 got %b exp 1", req_ready4); end
    exp_nl = '0; exp_ns = '0; exp_raddr = '0; exp_waddr = '0; exp_wdata = '0;
  endtask

  task automatic test_load_basic();
    logic [31:0] rd; int lat, wc, wa; logic tmo;
    run_op(1'b0, 16'h0003, 32'h0, 0, rd, lat, wc, wa, tmo);
    exp_nl++; exp_raddr = 16'h0003;
    n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL load_timeout got %b exp 0", tmo); end
    n_vec++; if (rd !== ref_mem[16'h0003]) begin n_err++; $display("FAIL load_data got %h exp %h", rd, ref_mem[16'h0003]); end
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL load_latency got %0d exp 1", lat); end
    n_vec++; if (n_loads !== exp_nl) begin n_err++; $display("FAIL load_count got %h exp %h", n_loads, exp_nl); end
    n_vec++; if (wc != 0) begin n_err++; $display("FAIL load_dm_we got %0d exp 0", wc); end
  endtask

  task automatic test_store_then_load();
    logic [31:0] rd; int lat, wc, wa; logic tmo;
    run_op(1'b1, 16'h0010, 32'hDEAD_BEEF, 0, rd, lat, wc, wa, tmo);
    ref_mem[16'h0010] = 32'hDEAD_BEEF; exp_ns++; exp_waddr = 16'h0010; exp_wdata = 32'hDEAD_BEEF;
    n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL store_timeout got %b exp 0", tmo); end
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL store_rdata got %h exp 0", rd); end
    n_vec++; if (lat != 2) begin n_err++; $display("FAIL store_latency got %0d exp 2", lat); end
    n_vec++; if (wc != 1 || wa != 1) begin n_err++; $display("FAIL store_we_pulse got %0d cyc at %0d exp 1 cyc at 1", wc, wa); end
    n_vec++; if (n_stores !== exp_ns) begin n_err++; $display("FAIL store_count got %h exp %h", n_stores, exp_ns); end
    run_op(1'b0, 16'h0010, 32'h0, 1, rd, lat, wc, wa, tmo);
    exp_nl++; exp_raddr = 16'h0010;
    n_vec++; if (rd !== ref_mem[16'h0010]) begin n_err++; $display("FAIL store_readback got %h exp %h", rd, ref_mem[16'h0010]); end
    n_vec++; if (dm_write_addr !== exp_waddr) begin n_err++; $display("FAIL load_kept_waddr got %h exp %h", dm_write_addr, exp_waddr); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_rd; int lat;
    exp_rd = ref_mem[16'h0020];
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL stall_pre_ready got %b exp 1", req_ready); end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0020;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 16'h0077; req_wdata = 32'hFFFF_0000;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    exp_raddr = 16'h0020;
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd) begin n_err++; $display("FAIL stall_rsp c%0d got %b/%h exp 1/%h", c, rsp_valid, rsp_rdata, exp_rd); end
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL stall_req_ready c%0d got %b exp 0", c, req_ready); end
      n_vec++; if (n_loads !== exp_nl || n_stores !== exp_ns) begin n_err++; $display("FAIL stall_counters c%0d got %h/%h exp %h/%h", c, n_loads, n_stores, exp_nl, exp_ns); end
      n_vec++; if (dm_write_addr !== exp_waddr || dm_we !== 1'b0) begin n_err++; $display("FAIL stall_ignored_store c%0d got %h/%b exp %h/0", c, dm_write_addr, dm_we, exp_waddr); end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_nl++;
    n_vec++; if (n_loads !== exp_nl) begin n_err++; $display("FAIL stall_handshake_count got %h exp %h", n_loads, exp_nl); end
    n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL stall_release got %b/%b exp 0/1", rsp_valid, req_ready); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b0 || n_loads !== exp_nl || n_stores !== exp_ns) begin n_err++; $display("FAIL idle_rsp_ready c%0d got %b/%h/%h exp 0/%h/%h", c, rsp_valid, n_loads, n_stores, exp_nl, exp_ns); end
    end
    rsp_ready = 1'b0;
    n_vec++; if (dm_read_addr !== exp_raddr) begin n_err++; $display("FAIL stall_raddr got %h exp %h", dm_read_addr, exp_raddr); end
  endtask

  task automatic test_rd_wait4();
    logic [31:0] newv;
    newv = 32'hC0FF_EE42;
    req_valid4 = 1'b1; req_we4 = 1'b0; req_addr4 = 16'h0042;
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      n_vec++; if (dm_read_addr4 !== 16'h0042) begin n_err++; $display("FAIL rw4_raddr k%0d got %h exp 0042", k, dm_read_addr4); end
      if (k < 4) begin
        n_vec++; if (rsp_valid4 !== 1'b0) begin n_err++; $display("FAIL rw4_early k%0d got %b exp 0", k, rsp_valid4); end
      end
      // Late data change exposes a capture before the final wait edge.
      if (k == 3) mem[16'h0042] = newv;
    end
    n_vec++; if (rsp_valid4 !== 1'b1 || rsp_rdata4 !== newv) begin n_err++; $display("FAIL rw4_capture got %b/%h exp 1/%h", rsp_valid4, rsp_rdata4, newv); end
    rsp_ready4 = 1'b1; @(posedge clk); #1; rsp_ready4 = 1'b0;
    n_vec++; if (n_loads4 !== 16'd1 || n_stores4 !== 16'd0) begin n_err++; $display("FAIL rw4_counts got %h/%h exp 0001/0000", n_loads4, n_stores4); end
    n_vec++; if ({dm_write_addr4, dm_write_data4, dm_we4} !== 49'h0) begin n_err++; $display("FAIL rw4_write_side got %h/%h/%b exp 0", dm_write_addr4, dm_write_data4, dm_we4); end
    ref_mem[16'h0042] = newv;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat, wc, wa; logic tmo;
    run_op(1'b1, 16'h0030, 32'h1357_9BDF, 0, rd, lat, wc, wa, tmo);
    ref_mem[16'h0030] = 32'h1357_9BDF; exp_ns++; exp_waddr = 16'h0030; exp_wdata = 32'h1357_9BDF;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b exp 1", req_ready); end
    run_op(1'b0, 16'h0030, 32'h0, 0, rd, lat, wc, wa, tmo);
    exp_nl++; exp_raddr = 16'h0030;
    n_vec++; if (rd !== ref_mem[16'h0030] || lat != 1) begin n_err++; $display("FAIL b2b_load got %h lat %0d exp %h lat 1", rd, lat, ref_mem[16'h0030]); end
    n_vec++; if (dm_write_data !== exp_wdata) begin n_err++; $display("FAIL b2b_wdata_hold got %h exp %h", dm_write_data, exp_wdata); end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, exp_rd; int lat, wc, wa; logic tmo, we; logic [15:0] addr; int unsigned hold;
    for (int n = 0; n < 30; n++) begin
      we = 1'($urandom); addr = 16'($urandom_range(1, 255)); wd = $urandom; hold = $urandom_range(0, 2);
      exp_rd = we ? 32'h0 : ref_mem[addr];
      run_op(we, addr, wd, hold, rd, lat, wc, wa, tmo);
      if (we) begin ref_mem[addr] = wd; exp_ns++; exp_waddr = addr; exp_wdata = wd; end
      else begin exp_nl++; exp_raddr = addr; end
      n_vec++; if (tmo !== 1'b0 || rd !== exp_rd) begin n_err++; $display("FAIL rnd_data n%0d we%b a%h got %h tmo %b exp %h", n, we, addr, rd, tmo, exp_rd); end
      n_vec++; if (lat != (we ? 2 : 1) || wc != (we ? 1 : 0)) begin n_err++; $display("FAIL rnd_timing n%0d got lat %0d we %0d exp %0d/%0d", n, lat, wc, we ? 2 : 1, we ? 1 : 0); end
      n_vec++; if (n_loads !== exp_nl || n_stores !== exp_ns) begin n_err++; $display("FAIL rnd_counts n%0d got %h/%h exp %h/%h", n, n_loads, n_stores, exp_nl, exp_ns); end
      n_vec++; if (dm_read_addr !== exp_raddr || dm_write_addr !== exp_waddr || dm_write_data !== exp_wdata) begin n_err++; $display("FAIL rnd_dm_hold n%0d got %h/%h/%h exp %h/%h/%h", n, dm_read_addr, dm_write_addr, dm_write_data, exp_raddr, exp_waddr, exp_wdata); end
    end
  endtask

  task automatic test_reset_mid_store();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0055; req_wdata = 32'hA5A5_5A5A;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (dm_we !== 1'b1) begin n_err++; $display("FAIL mid_store_we_high got %b exp 1", dm_we); end
    #2 rst_f = 1'b0;
    #1;
    n_vec++; if (dm_we !== 1'b0) begin n_err++; $display("FAIL async_dm_we got %b exp 0", dm_we); end
    n_vec++; if ({rsp_valid, req_ready} !== 2'b00 || rsp_rdata !== 32'h0) begin n_err++; $display("FAIL async_rsp got %b/%b/%h exp 0/0/0", rsp_valid, req_ready, rsp_rdata); end
    n_vec++; if ({dm_read_addr, dm_write_addr, dm_write_data, n_loads, n_stores} !== 96'h0) begin n_err++; $display("FAIL async_regs got %h/%h/%h/%h/%h exp 0", dm_read_addr, dm_write_addr, dm_write_data, n_loads, n_stores); end
    exp_nl = '0; exp_ns = '0; exp_raddr = '0; exp_waddr = '0; exp_wdata = '0;
    @(negedge clk); rst_f = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b0 || dm_we !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_store c%0d got %b/%b/%b exp 0/0/1", c, rsp_valid, dm_we, req_ready); end
    end
  endtask

  task automatic test_reset_mid_load();
    int lat;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0061;
    req_valid4 = 1'b1; req_we4 = 1'b0; req_addr4 = 16'h0062;
    @(posedge clk); #1; req_valid = 1'b0; req_valid4 = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_vec++; if (rsp_valid !== 1'b1 || rsp_valid4 !== 1'b0) begin n_err++; $display("FAIL mid_load_pre got %b/%b exp 1/0", rsp_valid, rsp_valid4); end
    #2 rst_f = 1'b0;
    #1;
    n_vec++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || dm_read_addr4 !== 16'h0) begin n_err++; $display("FAIL mid_load_rst got %b/%h/%h exp 0/0/0", rsp_valid, rsp_rdata, dm_read_addr4); end
    @(negedge clk); rst_f = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b0 || rsp_valid4 !== 1'b0 || n_loads !== 16'h0 || n_loads4 !== 16'h0) begin n_err++; $display("FAIL post_rst_load c%0d got %b/%b/%h/%h exp 0/0/0/0", c, rsp_valid, rsp_valid4, n_loads, n_loads4); end
    end
  endtask

  task automatic test_store_wrap();
    logic [31:0] rd; int lat, wc, wa; logic tmo;
    force dut.store_cnt = 16'hFFFE;
    #1 release dut.store_cnt;
    exp_ns = 16'hFFFE;
    for (int s = 0; s < 2; s++) begin
      run_op(1'b1, 16'h0080 + 16'(s), 32'h0BAD_0000 + 32'(s), 0, rd, lat, wc, wa, tmo);
      ref_mem[16'h0080 + 16'(s)] = 32'h0BAD_0000 + 32'(s); exp_ns++;
      n_vec++; if (n_stores !== exp_ns) begin n_err++; $display("FAIL store_wrap s%0d got %h exp %h", s, n_stores, exp_ns); end
    end
    n_vec++; if (n_loads !== exp_nl) begin n_err++; $display("FAIL wrap_loads_kept got %h exp %h", n_loads, exp_nl); end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid4 = 1'b0; req_we4 = 1'b0; req_addr4 = '0; req_wdata4 = '0; rsp_ready4 = 1'b0;
    for (int unsigned i = 0; i < 65536; i++) begin
      mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    mem[3] = 32'h0000_00AB;
    ref_mem[3] = 32'h0000_00AB;
    test_reset();
    test_load_basic();
    test_store_then_load();
    test_stall();
    test_rd_wait4();
    test_back_to_back();
    test_random();
    test_reset_mid_store();
    test_reset_mid_load();
    test_store_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d vectors applied, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end
endmodule

// File: doc/dm_ctrl.md
DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 SHALL provide parameter: RD_WAIT, default 1, dm read settle cycles before capture; legal range 1..15.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL provide port: rst_f  input  1  reset; asynchronous and active-low.
REQ-004 SHALL provide port: req_valid  input  1  core request present.
REQ-005 SHALL provide port: req_ready  output  1  block accepts request this cycle.
REQ-006 SHALL provide port: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL provide port: req_addr  input  16  word address.
REQ-008 SHALL provide port: req_wdata  input  32  store data.
REQ-009 SHALL provide port: rsp_valid  output  1  response present.
REQ-010 SHALL provide port: rsp_ready  input  1  core consumes response.
REQ-011 SHALL provide port: rsp_rdata  output  32  load data; 32'h0 for store responses.
REQ-012 SHALL provide port: dm_read_addr  output  16  to data memory read_addr.
REQ-013 SHALL provide port: dm_write_addr  output  16  to data memory write_addr.
REQ-014 SHALL provide port: dm_write_data  output  32  to data memory write_data.
REQ-015 SHALL provide port: dm_we  output  1  to data memory; write commits on its falling edge.
REQ-016 SHALL provide port: dm_read_data  input  32  from data memory read_data.
REQ-017 SHALL provide port: n_loads  output  16  completed-load count.
REQ-018 SHALL provide port: n_stores  output  16  completed-store count.

Function
REQ-019 SHALL implement states IDLE, RD_WAIT, WR_HI, WR_LO, RESP; all dm_* outputs and rsp_* outputs registered.
REQ-020 SHALL drive req_ready = 1 only in IDLE; a request is accepted on a posedge with req_valid && req_ready.
REQ-021 SHALL, on load accept at edge N: dm_read_addr <= req_addr, load wait counter with RD_WAIT, state -> RD_WAIT.
REQ-022 SHALL, in RD_WAIT, decrement the counter each edge; on the edge where counter == 1, capture dm_read_data into rsp_rdata, state -> RESP (rsp_valid high after edge N+RD_WAIT).
REQ-023 SHALL, on store accept at edge N: dm_write_addr <= req_addr, dm_write_data <= req_wdata, dm_we stays 0, state -> WR_HI.
REQ-024 SHALL, in WR_HI: dm_we <= 1, state -> WR_LO; in WR_LO: dm_we <= 0, rsp_rdata <= 0, state -> RESP (rsp_valid high after edge N+2).
REQ-025 SHALL keep dm_we high for exactly one cycle per store, never two consecutive cycles, and never high outside WR_LO.
REQ-026 SHALL hold dm_write_addr/dm_write_data stable from accept until the next store accept, and hold dm_read_addr stable until the next load accept; stores do not change dm_read_addr, loads do not change dm_write_*.
REQ-027 SHALL, in RESP, hold rsp_valid = 1 and rsp_rdata stable until rsp_ready = 1; on that edge rsp_valid <= 0, state -> IDLE.
REQ-028 SHALL give zero-bubble turnaround only from IDLE; earliest next accept is the edge after the response handshake.
REQ-029 SHALL ignore req_* in every non-IDLE state (no queuing); req_valid while busy is held off by req_ready = 0.
REQ-030 SHALL increment n_loads / n_stores by 1 on the response handshake edge of the matching operation; wrap FFFF -> 0000.
REQ-031 SHALL treat rsp_ready asserted when rsp_valid = 0 as no effect.

Reset
REQ-032 SHALL, on rst_f = 0, immediately force state IDLE, req_ready 0 during reset then 1 after release, rsp_valid 0, rsp_rdata 0, dm_read_addr 0, dm_write_addr 0, dm_write_data 0, dm_we 0, n_loads 0, n_stores 0, wait counter 0.
REQ-033 SHALL, if rst_f falls while dm_we = 1, drop dm_we asynchronously; the resulting memory write commit is accepted behaviour and no response is produced.
REQ-034 SHALL, if reset hits mid-load or in RESP, discard the operation; no response after release.

Verification
REQ-035 SHALL cover: load addr 0x0003, memory[3] = 0x0000_00AB, RD_WAIT=1, rsp_ready=1 -> rsp_valid one edge after accept, rsp_rdata = 0x0000_00AB, n_loads = 1.
REQ-036 SHALL cover: store 0xDEAD_BEEF to 0x0010 -> dm_we high exactly one cycle at N+1, falls at N+2, rsp_valid with rsp_rdata 0; subsequent load 0x0010 returns 0xDEAD_BEEF.
REQ-037 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready 0, new req_valid ignored, counters unchanged until handshake.
REQ-038 SHALL cover: RD_WAIT=4 load -> capture on edge N+4, dm_read_addr stable throughout.
REQ-039 SHALL cover: rst_f low during WR_LO -> dm_we 0 without waiting for clk, all outputs at reset values, no rsp_valid after release.
REQ-040 SHALL cover: n_stores preset by 65535 stores -> next store handshake gives n_stores = 0x0000.
